lsu_rmw: RTL and testbench

LSU_RMW -- requirements
Module: lsu_rmw

---
 rtl/lsu_pkg.sv | 24 ++
 rtl/lsu_lane_merge.sv | 51 +++++
 rtl/lsu_rmw.sv | 139 +++++++++++++
 tb/tb_lsu_rmw.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit with sub-word read-modify-write.
// Sizes, FSM states and word/byte width constants.
package lsu_pkg;

    localparam int XLEN   = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = XLEN / BYTE_W;
    localparam int DM_AW  = 10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_merge.sv
// Little-endian lane merge for stores and lane extract/extend for loads.
// Purely combinational; word-size accesses pass data straight through.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  lsu_size_e         size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   old_word,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rd_word,
    output logic [XLEN-1:0]   merged,
    output logic [XLEN-1:0]   ldata
);

    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   lanes;
    logic [BYTE_W-1:0] rd_b;
    logic [15:0]       rd_h;

    always_comb begin
        mask  = '1;
        lanes = wdata;
        unique case (size)
            SZ_BYTE: begin
                mask  = 32'h0000_00FF << {offset, 3'b000};
                lanes = {NBYTES{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask  = offset[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                lanes = {2{wdata[15:0]}};
            end
            default: begin
                mask  = '1;
                lanes = wdata;
            end
        endcase
        merged = (old_word & ~mask) | (lanes & mask);
    end

    always_comb begin
        rd_b = rd_word[{offset, 3'b000} +: BYTE_W];
        rd_h = offset[1] ? rd_word[31:16] : rd_word[15:0];
        unique case (size)
            SZ_BYTE: ldata = {{(XLEN-8){~is_unsigned & rd_b[7]}}, rd_b};
            SZ_HALF: ldata = {{(XLEN-16){~is_unsigned & rd_h[15]}}, rd_h};
            default: ldata = rd_word;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Single-request LSU: loads, word stores and sub-word read-modify-write stores.
// Define LSU_RANGE_CHECK_EN to reject addresses at or above 4 KiB.
module lsu_rmw
    import lsu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [DM_AW-1:0] dm_addr,
    output logic [31:0]      dm_din,
    output logic             dm_we,
    input  logic [31:0]      dm_dout
);

`ifdef LSU_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    lsu_state_e state, state_n;

    lsu_size_e   req_sz;
    logic        req_err;
    logic        accept;

    logic        we_q;
    lsu_size_e   size_q;
    logic        uns_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] merged;
    logic [31:0] ldata;

    assign req_sz = lsu_size_e'(req_size);
    assign accept = req_valid && (state == ST_IDLE);

    always_comb begin
        req_err = 1'b0;
        unique case (req_sz)
            SZ_HALF: req_err = req_addr[0];
            SZ_WORD: req_err = |req_addr[1:0];
            SZ_RSVD: req_err = 1'b1;
            default: req_err = 1'b0;
        endcase
        req_err = req_err | (RANGE_CHK & (|req_addr[31:12]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_n = ST_RESP;
                    else if (req_we && req_sz == SZ_WORD)
                        state_n = ST_WRITE;
                    else
                        state_n = ST_READ;
                end
            end
            ST_READ:  state_n = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_n = ST_RESP;
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        dm_we      = (state == ST_WRITE);
        dm_addr    = '0;
        dm_din     = '0;
        if (state == ST_READ || state == ST_WRITE)
            dm_addr = addr_q[11:2];
        if (state == ST_WRITE)
            dm_din = merged;
    end

    // Response registers are loaded on the edge into RESP and zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                size_q  <= req_sz;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr[11:0];
                wdata_q <= req_wdata;
            end
            if (state == ST_READ)
                word_q <= dm_dout;
            rdata_q <= (state == ST_READ && !we_q) ? ldata : '0;
            err_q   <= accept && req_err;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    lsu_lane_merge u_lane (
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .old_word    (word_q),
        .wdata       (wdata_q),
        .rd_word     (dm_dout),
        .merged      (merged),
        .ldata       (ldata)
    );

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw with a behavioural data memory.
// Vector table plus reset-abort sequence; responses checked via a scoreboard queue.
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  dm_addr;
    logic [31:0] dm_din;
    logic        dm_we;
    logic [31:0] dm_dout;

    logic [31:0] mem [1024];
    int          we_cnt = 0;
    logic [31:0] last_din;
    logic [9:0]  last_waddr;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nwe;
        logic [31:0] din;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb_q[$];

    always #5 clk = ~clk;

    lsu_rmw dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_addr      (dm_addr),
        .dm_din       (dm_din),
        .dm_we        (dm_we),
        .dm_dout      (dm_dout)
    );

    assign dm_dout = mem[dm_addr];

    always @(posedge clk) begin
        if (dm_we) begin
            mem[dm_addr] <= dm_din;
            we_cnt       = we_cnt + 1;
            last_din     = dm_din;
            last_waddr   = dm_addr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] sz,
                                input logic uns, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic err, input int lat,
                                input int nwe, input logic [31:0] din);
        vec_t t;
        t.we = we; t.size = sz; t.uns = uns; t.addr = a;
        t.wdata = wd; t.rdata = rd; t.err = err; t.lat = lat;
        t.nwe = nwe; t.din = din;
        return t;
    endfunction

    task automatic run(input vec_t t, input string nm);
        int          lat;
        int          w0;
        logic [32:0] e;
        @(negedge clk);
        chk({nm, ".ready"}, {31'b0, req_ready}, 32'd1);
        chk({nm, ".idle_addr"}, {22'b0, dm_addr}, 32'd0);
        chk({nm, ".idle_rdata"}, resp_rdata, 32'd0);
        req_valid    = 1'b1;
        req_we       = t.we;
        req_size     = t.size;
        req_unsigned = t.uns;
        req_addr     = t.addr;
        req_wdata    = t.wdata;
        sb_q.push_back({t.err, t.rdata});
        w0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 32'hX5A5_A5A5;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 10);
        if (!resp_valid) begin
            chk({nm, ".timeout"}, {31'b0, resp_valid}, 32'd1);
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            chk({nm, ".rdata"}, resp_rdata, e[31:0]);
            chk({nm, ".err"}, {31'b0, resp_err}, {31'b0, e[32]});
            chk({nm, ".latency"}, 32'(lat), 32'(t.lat));
        end
        chk({nm, ".nwe"}, 32'(we_cnt - w0), 32'(t.nwe));
        if (t.nwe > 0) begin
            chk({nm, ".din"}, last_din, t.din);
            chk({nm, ".waddr"}, {22'b0, last_waddr}, {22'b0, t.addr[11:2]});
        end
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, ".ready"}, {31'b0, req_ready}, 32'd1);
        chk({nm, ".valid"}, {31'b0, resp_valid}, 32'd0);
        chk({nm, ".rdata"}, resp_rdata, 32'd0);
        chk({nm, ".err"}, {31'b0, resp_err}, 32'd0);
        chk({nm, ".we"}, {31'b0, dm_we}, 32'd0);
        chk({nm, ".addr"}, {22'b0, dm_addr}, 32'd0);
        chk({nm, ".din"}, dm_din, 32'd0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

        vecs.push_back(mk(1, 2'b10, 0, 32'h010, 32'hDEADBEEF, 0, 0, 2, 1, 32'hDEADBEEF));
        vecs.push_back(mk(0, 2'b10, 0, 32'h010, 0, 32'hDEADBEEF, 0, 2, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h010, 32'h11223344, 0, 0, 2, 1, 32'h11223344));
        vecs.push_back(mk(1, 2'b00, 0, 32'h012, 32'hFFFFFFAA, 0, 0, 3, 1, 32'h11AA3344));
        vecs.push_back(mk(0, 2'b10, 0, 32'h010, 0, 32'h11AA3344, 0, 2, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h012, 0, 32'hFFFFFFAA, 0, 2, 0, 0));
        vecs.push_back(mk(0, 2'b00, 1, 32'h012, 0, 32'h000000AA, 0, 2, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h010, 32'h80013344, 0, 0, 2, 1, 32'h80013344));
        vecs.push_back(mk(0, 2'b01, 0, 32'h012, 0, 32'hFFFF8001, 0, 2, 0, 0));
        vecs.push_back(mk(0, 2'b01, 1, 32'h012, 0, 32'h00008001, 0, 2, 0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h010, 32'hABCD1234, 0, 0, 3, 1, 32'h80011234));
        vecs.push_back(mk(0, 2'b01, 0, 32'h010, 0, 32'h00001234, 0, 2, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h011, 0, 32'h00000012, 0, 2, 0, 0));
        vecs.push_back(mk(0, 2'b00, 0, 32'h013, 0, 32'hFFFFFF80, 0, 2, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h013, 32'h12345678, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b01, 0, 32'h011, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'b01, 0, 32'h013, 32'h5555, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 2'b11, 0, 32'h010, 0, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'b11, 0, 32'h010, 32'h1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 32'h000, 32'h00000055, 0, 0, 2, 1, 32'h00000055));
        vecs.push_back(mk(1, 2'b00, 0, 32'h003, 32'h0000009C, 0, 0, 3, 1, 32'h9C000055));
`ifdef LSU_RANGE_CHECK_EN
        vecs.push_back(mk(0, 2'b10, 0, 32'h1000, 0, 0, 1, 1, 0, 0));
`else
        vecs.push_back(mk(0, 2'b10, 0, 32'h1000, 0, 32'h9C000055, 0, 2, 0, 0));
`endif

        #2;
        chk_reset_outs("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run(vecs[i], $sformatf("v%0d", i));

        run(mk(1, 2'b10, 0, 32'h010, 32'h0BADF00D, 0, 0, 2, 1, 32'h0BADF00D), "pre_rst");
        @(negedge clk);
        w0 = we_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h012; req_wdata = 32'h77;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort.in_read", {22'b0, dm_addr}, 32'd4);
        rst = 1'b1;
        #1;
        chk_reset_outs("abort");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("abort.nwe", 32'(we_cnt - w0), 32'd0);
        run(mk(0, 2'b10, 0, 32'h010, 0, 32'h0BADF00D, 0, 2, 0, 0), "post_rst");

        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
